hit_receiver: RTL

- Consumes the per-frame hit pulses `hitP1`/`hitP2` produced by the punch/attack logic.
- Applies damage to each player's health and runs a per-player hitstun / invulnerability state machine.
- Drives a knockback velocity directed away from the attacker.
- Detects KO and round end. Sits between combat detection and the sprite motion and health-bar/HUD logic.

---
 rtl/hit_receiver_if.sv | 33 +++
 rtl/hit_receiver.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hit_receiver_if.sv
// Bus between combat detection and the hit receiver: hit pulses and
// positions in, health/stun/knockback/round status out.
interface hit_receiver_if;
  logic               hitP1;
  logic               hitP2;
  logic signed [31:0] P1Xpos;
  logic signed [31:0] P2Xpos;
  logic               new_round;
  logic [7:0]         P1Health;
  logic [7:0]         P2Health;
  logic               P1Stun;
  logic               P2Stun;
  logic signed [31:0] P1Knockback;
  logic signed [31:0] P2Knockback;
  logic               P1Invuln;
  logic               P2Invuln;
  logic               round_over;
  logic [1:0]         winner;

  // Combat/game logic side: drives hits and positions, reads status.
  modport master (
    output hitP1, hitP2, P1Xpos, P2Xpos, new_round,
    input  P1Health, P2Health, P1Stun, P2Stun, P1Knockback, P2Knockback,
           P1Invuln, P2Invuln, round_over, winner
  );

  // Hit receiver side.
  modport slave (
    input  hitP1, hitP2, P1Xpos, P2Xpos, new_round,
    output P1Health, P2Health, P1Stun, P2Stun, P1Knockback, P2Knockback,
           P1Invuln, P2Invuln, round_over, winner
  );
endinterface

// File: rtl/hit_receiver.sv
// Hit receiver: applies damage, runs a per-player IDLE/STUN/INVULN/KO
// machine, drives knockback away from the attacker and tracks round end.
// Index 0 is P1, index 1 is P2 throughout.
module hit_receiver #(
  parameter int MAX_HEALTH    = 100,
  parameter int DAMAGE        = 10,
  parameter int STUN_FRAMES   = 12,
  parameter int INVULN_FRAMES = 20,
  parameter int KB_SPEED      = 4
) (
  input logic           frame_clk,
  input logic           Reset,
  hit_receiver_if.slave bus
);

  localparam int CNT_MAX = (STUN_FRAMES > INVULN_FRAMES) ? STUN_FRAMES : INVULN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, STUN, INVULN, KO} state_t;

  state_t             st_q   [2];
  state_t             st_d   [2];
  logic [7:0]         hp_q   [2];
  logic [7:0]         hp_d   [2];
  logic [CNT_W-1:0]   cnt_q  [2];
  logic [CNT_W-1:0]   cnt_d  [2];
  logic               kb_neg_q [2];
  logic [1:0]         accept;
  logic [1:0]         ko_enter;
  logic [1:0]         hit;
  logic [1:0]         neg_on_hit;
  logic               p1_left;
  logic               round_over_q;
  logic               round_over_d;
  logic [1:0]         winner_q;
  logic [1:0]         winner_d;
  logic               restart;

  // Health minus one hit, floored at zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] h);
    if (int'(h) <= DAMAGE) return 8'd0;
    return h - 8'(DAMAGE);
  endfunction

  // Knockback is only applied while stunned; KO and INVULN stand still.
  function automatic logic signed [31:0] kb_value(input state_t s, input logic neg);
    logic signed [31:0] mag;
    mag = 32'(KB_SPEED);
    if (s != STUN) return 32'sd0;
    return neg ? -mag : mag;
  endfunction

  assign hit        = {bus.hitP2, bus.hitP1};
  assign p1_left    = (bus.P1Xpos <= bus.P2Xpos);
  // The player on the left is pushed further left (negative velocity).
  assign neg_on_hit = {~p1_left, p1_left};
  assign restart    = Reset | (bus.new_round & round_over_q);

  // Next-state, damage and counter logic for both players plus round control.
  always_comb begin
    accept       = 2'b00;
    ko_enter     = 2'b00;
    round_over_d = round_over_q;
    winner_d     = winner_q;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      hp_d[i]  = hp_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        IDLE: begin
          if (hit[i] && !round_over_q) begin
            accept[i] = 1'b1;
            hp_d[i]   = sat_sub(hp_q[i]);
            if (hp_d[i] == 8'd0) begin
              st_d[i]     = KO;
              ko_enter[i] = 1'b1;
            end else begin
              st_d[i]  = STUN;
              cnt_d[i] = CNT_W'(STUN_FRAMES - 1);
            end
          end
        end
        STUN: begin
          if (cnt_q[i] == '0) begin
            st_d[i]  = INVULN;
            cnt_d[i] = CNT_W'(INVULN_FRAMES - 1);
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        INVULN: begin
          if (cnt_q[i] == '0) st_d[i] = IDLE;
          else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        default: ;
      endcase
    end
    // Bit 1 (P2 wins) set when P1 is KO'd, bit 0 (P1 wins) when P2 is.
    if (|ko_enter) begin
      round_over_d = 1'b1;
      winner_d     = {ko_enter[0], ko_enter[1]};
    end
  end

  // Control state: FSMs, health, counters and round status; reset or an
  // honoured new_round restarts the round.
  always_ff @(posedge frame_clk) begin
    if (restart) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= IDLE;
        hp_q[i]  <= 8'(MAX_HEALTH);
        cnt_q[i] <= '0;
      end
      round_over_q <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        hp_q[i]  <= hp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      round_over_q <= round_over_d;
      winner_q     <= winner_d;
    end
  end

  // Knockback direction latched at hit acceptance; only read while in STUN,
  // so it needs no reset.
  always_ff @(posedge frame_clk) begin
    for (int i = 0; i < 2; i++)
      if (accept[i]) kb_neg_q[i] <= neg_on_hit[i];
  end

  assign bus.P1Health    = hp_q[0];
  assign bus.P2Health    = hp_q[1];
  assign bus.P1Stun      = (st_q[0] == STUN) || (st_q[0] == KO);
  assign bus.P2Stun      = (st_q[1] == STUN) || (st_q[1] == KO);
  assign bus.P1Invuln    = (st_q[0] == INVULN);
  assign bus.P2Invuln    = (st_q[1] == INVULN);
  assign bus.P1Knockback = kb_value(st_q[0], kb_neg_q[0]);
  assign bus.P2Knockback = kb_value(st_q[1], kb_neg_q[1]);
  assign bus.round_over  = round_over_q;
  assign bus.winner      = winner_q;

endmodule
